// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer for IMEM req/rsp, decode hand-off and
// PC writeback operands (jr beats br; redirects flush in-flight fetches).
// Ports: clk, rst_n | pc | imem_req_{valid,addr,ready} imem_rsp_{valid,data}
//   | instr_valid instr instr_pc stall | br_{valid,base,imm} jr_{valid,reg,imm}
//   | pc_wb_en pc_mode pc_new imm reg_val flush
module pc_fetch_ctrl #(
  parameter int XLEN         = 64,
  parameter int ILEN         = 32,
  parameter int PC_MODE_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         pc,
  output logic                    imem_req_valid,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [ILEN-1:0]         imem_rsp_data,
  output logic                    instr_valid,
  output logic [ILEN-1:0]         instr,
  output logic [XLEN-1:0]         instr_pc,
  input  logic                    stall,
  input  logic                    br_valid,
  input  logic [XLEN-1:0]         br_base,
  input  logic [ILEN-1:0]         br_imm,
  input  logic                    jr_valid,
  input  logic [XLEN-1:0]         jr_reg,
  input  logic [ILEN-1:0]         jr_imm,
  output logic                    pc_wb_en,
  output logic [PC_MODE_BITS-1:0] pc_mode,
  output logic [XLEN-1:0]         pc_new,
  output logic [ILEN-1:0]         imm,
  output logic [XLEN-1:0]         reg_val,
  output logic                    flush
);

  localparam logic [PC_MODE_BITS-1:0] PC_4   = PC_MODE_BITS'(0);
  localparam logic [PC_MODE_BITS-1:0] PC_IMM = PC_MODE_BITS'(1);
  localparam logic [PC_MODE_BITS-1:0] PC_REG = PC_MODE_BITS'(2);

  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       redir;
  logic       consume;
  logic       hs;
  logic       capture;

  always_comb begin
    redir   = (state != BOOT) && (jr_valid || br_valid);
    hs      = (state == REQ) && imem_req_ready;
    consume = instr_valid && !stall;
    capture = (state == WAIT) && imem_rsp_valid
              && !instr_valid && !redir;
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = imem_req_valid ? pc : '0;
    pc_wb_en = 1'b0;
    pc_mode  = PC_4;
    pc_new   = '0;
    imm      = '0;
    reg_val  = '0;
    flush    = 1'b0;
    if (redir) begin
      pc_wb_en = 1'b1;
      flush    = 1'b1;
      if (jr_valid) begin
        pc_mode = PC_REG;
        reg_val = jr_reg;
        imm     = jr_imm;
      end else begin
        pc_mode = PC_IMM;
        pc_new  = br_base;
        imm     = br_imm;
      end
    end else if (consume) begin
      pc_wb_en = 1'b1;
      pc_new   = pc;
    end
  end

  // A redirect in WAIT only needs DRAIN while the response is still
  // owed; once it has arrived (same cycle or earlier) nothing is in flight.
  always_comb begin
    state_nx = state;
    case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        if (hs) state_nx = redir ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redir)
          state_nx = (imem_rsp_valid || instr_valid) ? REQ : DRAIN;
        else if (consume)
          state_nx = REQ;
        else if (instr_valid)
          state_nx = HOLD;
      end
      HOLD: begin
        if (redir || consume) state_nx = REQ;
      end
      DRAIN: begin
        if (imem_rsp_valid) state_nx = REQ;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        instr_valid <= 1'b1;
        instr       <= imem_rsp_data;
        instr_pc    <= pc;
      end else if (consume || redir) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scenario tasks plus a randomized run checked against
// an architectural next-PC model; IMEM and PC writeback unit modelled here.
module tb_pc_fetch_ctrl;

  localparam logic [1:0] M_PC4 = 2'd0;
  localparam logic [1:0] M_IMM = 2'd1;
  localparam logic [1:0] M_REG = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [63:0] br_base = '0;
  logic [31:0] br_imm = '0;
  logic        jr_valid = 1'b0;
  logic [63:0] jr_reg = '0;
  logic [31:0] jr_imm = '0;
  logic        pc_wb_en;
  logic [1:0]  pc_mode;
  logic [63:0] pc_new;
  logic [31:0] imm;
  logic [63:0] reg_val;
  logic        flush;

  int n_chk = 0;
  int n_fail = 0;
  bit use_nop = 1'b1;
  int lat = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .stall(stall),
    .br_valid(br_valid), .br_base(br_base), .br_imm(br_imm),
    .jr_valid(jr_valid), .jr_reg(jr_reg), .jr_imm(jr_imm),
    .pc_wb_en(pc_wb_en), .pc_mode(pc_mode), .pc_new(pc_new),
    .imm(imm), .reg_val(reg_val), .flush(flush)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (use_nop) return 32'h0000_0013;
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // PC writeback unit
  always @(posedge clk) begin
    if (pc_wb_en) begin
      case (pc_mode)
        M_IMM:   pc <= pc_new + sext(imm);
        M_REG:   pc <= reg_val + sext(imm);
        default: pc <= pc + 64'd4;
      endcase
    end
  end

  // IMEM: response lat cycles after the accepting edge (0 = next cycle)
  int pend = 0;
  logic [63:0] paddr = '0;
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (pend > 0) begin
      if (pend == 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(paddr);
      end
      pend <= pend - 1;
    end
    if (imem_req_valid && imem_req_ready) begin
      if (lat == 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(imem_req_addr);
        pend <= 0;
      end else begin
        pend  <= lat;
        paddr <= imem_req_addr;
      end
    end
  end

  task automatic clear_in();
    stall = 1'b0;
    br_valid = 1'b0;
    jr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    br_valid = 1'b1;
    jr_valid = 1'b1;
    br_base = 64'h40;
    jr_reg = 64'h80;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h0)
      $display("FAIL reset_req: got %b/%h want 0/0",
               imem_req_valid, imem_req_addr);
    else n_chk += 0;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h0) n_fail++;
    n_chk++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got %b/%h/%h want 0/0/0",
               instr_valid, instr, instr_pc);
    end
    n_chk++;
    if (pc_wb_en !== 1'b0 || flush !== 1'b0 || pc_mode !== M_PC4) begin
      n_fail++;
      $display("FAIL reset_wb: got wb %b fl %b mode %0d want 0 0 0",
               pc_wb_en, flush, pc_mode);
    end
    n_chk++;
    if (pc_new !== 64'h0 || imm !== 32'h0 || reg_val !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0",
               pc_new, imm, reg_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0 || pc_wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_idle: got req %b wb %b want 0 0",
               imem_req_valid, pc_wb_en);
    end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [63:0] addrs[$];
    int ivc[$];
    int wbn = 0;
    lat = 0;
    imem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (imem_req_valid) addrs.push_back(imem_req_addr);
      if (instr_valid) begin
        ivc.push_back(c);
        n_chk++;
        if (instr !== 32'h13) begin
          n_fail++;
          $display("FAIL seq_instr: got %h want 00000013", instr);
        end
      end
      if (pc_wb_en) begin
        wbn++;
        n_chk++;
        if (pc_mode !== M_PC4 || !instr_valid) begin
          n_fail++;
          $display("FAIL seq_wb_mode: got mode %0d iv %b want 0 1",
                   pc_mode, instr_valid);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (addrs.size() != 4) begin
      n_fail++;
      $display("FAIL seq_nreq: got %0d want 4", addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (addrs[i] !== 64'(4 * i)) begin
          n_fail++;
          $display("FAIL seq_addr%0d: got %h want %h", i, addrs[i], 4 * i);
        end
      end
    end
    n_chk++;
    if (ivc.size() != 4 || wbn != 4) begin
      n_fail++;
      $display("FAIL seq_count: got iv %0d wb %0d want 4 4",
               ivc.size(), wbn);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (ivc[i+1] - ivc[i] != 3) begin
          n_fail++;
          $display("FAIL seq_rate: got gap %0d want 3", ivc[i+1] - ivc[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    logic [31:0] s_i;
    logic [63:0] s_p;
    for (int k = 0; k < 10; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL stall_wait: got no instr_valid want 1");
      return;
    end
    stall = 1'b1;
    #1;
    s_i = instr;
    s_p = instr_pc;
    n_chk++;
    if (s_p !== 64'h10) begin
      n_fail++;
      $display("FAIL stall_pc: got %h want 10", s_p);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      n_chk++;
      if (instr_valid !== 1'b1 || instr !== s_i || instr_pc !== s_p
          || pc_wb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got iv %b %h %h wb %b want 1 %h %h 0",
                 i, instr_valid, instr, instr_pc, pc_wb_en, s_i, s_p);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    n_chk++;
    if (pc_wb_en !== 1'b1 || pc_mode !== M_PC4 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got wb %b mode %0d fl %b want 1 0 0",
               pc_wb_en, pc_mode, flush);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (instr_valid !== 1'b0 || pc_wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_after: got iv %b wb %b want 0 0",
               instr_valid, pc_wb_en);
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    bit found = 1'b0;
    int ivn = 0;
    int wbn = 0;
    logic [63:0] na = '1;
    lat = 2;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL br_hs: got no handshake want 1");
      return;
    end
    @(negedge clk);
    br_valid = 1'b1;
    br_base = 64'h100;
    br_imm = 32'hFFFF_FFF8;
    #1;
    n_chk++;
    if (pc_wb_en !== 1'b1 || flush !== 1'b1 || pc_mode !== M_IMM
        || pc_new !== 64'h100 || imm !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL br_wb: got wb %b fl %b mode %0d %h %h want 1 1 1 100 fffffff8",
               pc_wb_en, flush, pc_mode, pc_new, imm);
    end
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL br_drain: got req %b want 0", imem_req_valid);
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (instr_valid) ivn++;
      if (pc_wb_en) wbn++;
      if (imem_req_valid) begin
        na = imem_req_addr;
        found = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!found || na !== 64'hF8) begin
      n_fail++;
      $display("FAIL br_target: got %h want f8", na);
    end
    n_chk++;
    if (ivn != 0 || wbn != 0) begin
      n_fail++;
      $display("FAIL br_discard: got iv %0d wb %0d want 0 0", ivn, wbn);
    end
    @(negedge clk);
  endtask

  task automatic test_jr_over_br();
    bit found = 1'b0;
    int ivn = 0;
    int wbn = 0;
    logic [63:0] na = '1;
    stall = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL jr_wait: got no instr_valid want 1");
      return;
    end
    jr_valid = 1'b1;
    jr_reg = 64'h2000;
    jr_imm = 32'h10;
    br_valid = 1'b1;
    br_base = 64'h500;
    br_imm = 32'h40;
    #1;
    n_chk++;
    if (instr_pc !== 64'hF8) begin
      n_fail++;
      $display("FAIL jr_tgt_instr: got %h want f8", instr_pc);
    end
    n_chk++;
    if (pc_wb_en !== 1'b1 || flush !== 1'b1 || pc_mode !== M_REG
        || reg_val !== 64'h2000 || imm !== 32'h10) begin
      n_fail++;
      $display("FAIL jr_wb: got wb %b fl %b mode %0d %h %h want 1 1 2 2000 10",
               pc_wb_en, flush, pc_mode, reg_val, imm);
    end
    @(negedge clk);
    clear_in();
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (instr_valid) ivn++;
      if (pc_wb_en) wbn++;
      if (imem_req_valid) begin
        na = imem_req_addr;
        found = 1'b0;
        break;
      end
    end
    n_chk++;
    if (na !== 64'h2010) begin
      n_fail++;
      $display("FAIL jr_target: got %h want 2010", na);
    end
    n_chk++;
    if (ivn != 0 || wbn != 0) begin
      n_fail++;
      $display("FAIL jr_single: got iv %0d extra wb %0d want 0 0", ivn, wbn);
    end
    @(negedge clk);
  endtask

  task automatic test_ready_hold();
    bit found = 1'b0;
    imem_req_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!found || imem_req_addr !== 64'h2014) begin
      n_fail++;
      $display("FAIL rdy_first: got %b %h want 1 2014",
               found, imem_req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2014) begin
        n_fail++;
        $display("FAIL rdy_hold%0d: got %b %h want 1 2014",
                 i, imem_req_valid, imem_req_addr);
      end
    end
    @(negedge clk);
    br_valid = 1'b1;
    br_base = 64'h300;
    br_imm = 32'h4;
    #1;
    n_chk++;
    if (pc_wb_en !== 1'b1 || flush !== 1'b1 || pc_mode !== M_IMM) begin
      n_fail++;
      $display("FAIL rdy_redir: got wb %b fl %b mode %0d want 1 1 1",
               pc_wb_en, flush, pc_mode);
    end
    @(negedge clk);
    br_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h304) begin
      n_fail++;
      $display("FAIL rdy_reissue: got %b %h want 1 304",
               imem_req_valid, imem_req_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    n_chk++;
    if (!found || instr_pc !== 64'h304) begin
      n_fail++;
      $display("FAIL rdy_deliver: got %b %h want 1 304", found, instr_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int ivn = 0;
    lat = 2;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!found || imem_req_addr !== 64'h308) begin
      n_fail++;
      $display("FAIL rst_hs: got %b %h want 1 308", found, imem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0
        || pc_wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got %b %b %b want 0 0 0",
               imem_req_valid, instr_valid, pc_wb_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (instr_valid) ivn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    #1;
    if (instr_valid) ivn++;
    n_chk++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_boot: got req %b want 0", imem_req_valid);
    end
    @(negedge clk);
    #1;
    if (instr_valid) ivn++;
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h308) begin
      n_fail++;
      $display("FAIL rst_refetch: got %b %h want 1 308",
               imem_req_valid, imem_req_addr);
    end
    n_chk++;
    if (ivn != 0) begin
      n_fail++;
      $display("FAIL rst_late_rsp: got %0d instr_valid want 0", ivn);
    end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    n_chk++;
    if (!found || instr_pc !== 64'h308) begin
      n_fail++;
      $display("FAIL rst_deliver: got %b %h want 1 308", found, instr_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] exp_pc;
    int outst = 0;
    int dlv = 0;
    int r;
    logic [31:0] t;
    rst_n = 1'b0;
    clear_in();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    use_nop = 1'b0;
    exp_pc = pc;
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      imem_req_ready = ($urandom_range(0, 99) < 70);
      lat = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      jr_valid = (i > 1) && (r < 5);
      br_valid = (i > 1) && (r >= 3) && (r < 9);
      jr_reg = {$urandom, $urandom} & ~64'h3;
      t = $urandom;
      jr_imm = {{20{t[11]}}, t[11:2], 2'b00};
      br_base = {32'h0, $urandom} & ~64'h3;
      t = $urandom;
      br_imm = {{20{t[12]}}, t[12:1], 1'b0} & ~32'h3;
      #1;
      if (imem_rsp_valid) outst--;
      if (imem_req_valid) begin
        n_chk++;
        if (imem_req_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL rnd_addr@%0d: got %h want %h",
                   i, imem_req_addr, exp_pc);
        end
        if (imem_req_ready) begin
          n_chk++;
          if (outst != 0) begin
            n_fail++;
            $display("FAIL rnd_outst@%0d: got %0d want 0", i, outst);
          end
          outst++;
        end
      end
      if (instr_valid) begin
        dlv++;
        n_chk++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_instr@%0d: got %h/%h want %h/%h",
                   i, instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
      end
      n_chk++;
      if (jr_valid) begin
        if (pc_wb_en !== 1'b1 || flush !== 1'b1 || pc_mode !== M_REG
            || reg_val !== jr_reg || imm !== jr_imm) begin
          n_fail++;
          $display("FAIL rnd_jr@%0d: got %b %b %0d %h %h want 1 1 2 %h %h",
                   i, pc_wb_en, flush, pc_mode, reg_val, imm, jr_reg, jr_imm);
        end
        exp_pc = jr_reg + sext(jr_imm);
      end else if (br_valid) begin
        if (pc_wb_en !== 1'b1 || flush !== 1'b1 || pc_mode !== M_IMM
            || pc_new !== br_base || imm !== br_imm) begin
          n_fail++;
          $display("FAIL rnd_br@%0d: got %b %b %0d %h %h want 1 1 1 %h %h",
                   i, pc_wb_en, flush, pc_mode, pc_new, imm, br_base, br_imm);
        end
        exp_pc = br_base + sext(br_imm);
      end else if (instr_valid && !stall) begin
        if (pc_wb_en !== 1'b1 || flush !== 1'b0 || pc_mode !== M_PC4) begin
          n_fail++;
          $display("FAIL rnd_pc4@%0d: got %b %b %0d want 1 0 0",
                   i, pc_wb_en, flush, pc_mode);
        end
        exp_pc = exp_pc + 64'd4;
      end else begin
        if (pc_wb_en !== 1'b0 || flush !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_idle@%0d: got wb %b fl %b want 0 0",
                   i, pc_wb_en, flush);
        end
      end
      @(negedge clk);
    end
    clear_in();
    n_chk++;
    if (dlv < 50) begin
      n_fail++;
      $display("FAIL rnd_progress: got %0d delivered want >=50", dlv);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jr_over_br();
    test_ready_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
